// File: rtl/filter_seq_pkg.sv
// Shared state encoding and sizing helpers for the mean-filter frame sequencer.
package filter_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACTIVE,
    S_HBLK,
    S_VBLK,
    S_DRAIN
  } seq_state_t;

  // Bits needed for a counter running 0..n-1 (never narrower than 1).
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic longint frame_size(input int w, input int h);
    return longint'(w) * longint'(h);
  endfunction

endpackage

// File: rtl/filter_line_timer.sv
// Pixel/row/blanking counters for the frame sequencer; strobes are combinational from registered counts.
// No flow control: counters advance every cycle the matching state is active.
module filter_line_timer
  import filter_seq_pkg::*;
#(
  parameter int WIDTH_IMG  = 512,
  parameter int HEIGHT_IMG = 512,
  parameter int HBLANK     = 4,
  parameter int VBLANK     = 600
) (
  input  logic clk,
  input  logic rstb,
  input  logic clr,
  input  logic in_active,
  input  logic in_hblk,
  input  logic in_vblk,
  output logic eor,
  output logic eof,
  output logic hblk_end,
  output logic vblk_end
);

  localparam int PW = cnt_w(WIDTH_IMG);
  localparam int RW = cnt_w(HEIGHT_IMG);
  localparam int BW = cnt_w((HBLANK > VBLANK) ? HBLANK : VBLANK);

  localparam logic [PW-1:0] PIX_LAST = PW'(WIDTH_IMG - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT_IMG - 1);
  localparam logic [BW-1:0] HB_LAST  = BW'(HBLANK - 1);
  localparam logic [BW-1:0] VB_LAST  = BW'(VBLANK - 1);

  logic [PW-1:0] pix_q;
  logic [RW-1:0] row_q;
  logic [BW-1:0] blk_q;

  assign eor      = in_active && (pix_q == PIX_LAST);
  assign eof      = eor && (row_q == ROW_LAST);
  assign hblk_end = in_hblk && (blk_q == HB_LAST);
  assign vblk_end = in_vblk && (blk_q == VB_LAST);

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      pix_q <= '0;
      row_q <= '0;
      blk_q <= '0;
    end else begin
      if (clr) begin
        pix_q <= '0;
        row_q <= '0;
      end else begin
        if (in_active) pix_q <= eor ? '0 : pix_q + PW'(1);
        if (hblk_end)  row_q <= row_q + RW'(1);
      end
      // One blank counter serves both gaps; it idles at zero outside them.
      if ((in_hblk && !hblk_end) || (in_vblk && !vblk_end)) blk_q <= blk_q + BW'(1);
      else                                                  blk_q <= '0;
    end
  end

endmodule

// File: rtl/filter_frame_sequencer.sv
// Replays a stored frame to the 3x3 mean filter as raster video (2-cycle rd_en->o_hav lag) and captures results.
// No backpressure: results are written as they arrive; SEQ_TIMEOUT_EN adds the drain watchdog and err.
module filter_frame_sequencer
  import filter_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 18,
  parameter int WIDTH_IMG  = 512,
  parameter int HEIGHT_IMG = 512,
  parameter int HBLANK     = 4,
  parameter int VBLANK     = 600,
  parameter int TIMEOUT    = 4096
) (
  input  logic                  clk,
  input  logic                  rstb,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  o_hav,
  output logic                  o_vav,
  output logic [DATA_WIDTH-1:0] o_data,
  input  logic                  f_wr_file,
  input  logic [DATA_WIDTH-1:0] f_data_out,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data
`ifdef SEQ_TIMEOUT_EN
  ,
  output logic                  err
`endif
);

  localparam longint FRAME_SZ = frame_size(WIDTH_IMG, HEIGHT_IMG);
  localparam logic [ADDR_WIDTH:0] FRAME_N = FRAME_SZ[ADDR_WIDTH:0];

  if (FRAME_SZ > (longint'(1) << ADDR_WIDTH) || HBLANK < 1 ||
      VBLANK < WIDTH_IMG + 16 || TIMEOUT < 1) begin : g_param_check
    $error("filter_frame_sequencer: illegal parameter set");
  end

  seq_state_t state_q, state_d;
  logic done_d, accept, timeout_hit;
  logic eor, eof, hblk_end, vblk_end;
  logic hav_d1, vav_d1, in_line;
  logic [ADDR_WIDTH:0] cap_q;
  logic cap_room, frame_full;

  // A start coinciding with done is ignored even though the FSM is already idle.
  assign accept     = (state_q == S_IDLE) && start && !done;
  assign busy       = (state_q != S_IDLE);
  assign rd_en      = (state_q == S_ACTIVE);
  assign in_line    = (state_q == S_ACTIVE) || (state_q == S_HBLK);
  assign cap_room   = (cap_q != FRAME_N);
  assign frame_full = !cap_room;

  filter_line_timer #(
    .WIDTH_IMG (WIDTH_IMG),
    .HEIGHT_IMG(HEIGHT_IMG),
    .HBLANK    (HBLANK),
    .VBLANK    (VBLANK)
  ) u_timer (
    .clk      (clk),
    .rstb     (rstb),
    .clr      (state_q == S_IDLE),
    .in_active(state_q == S_ACTIVE),
    .in_hblk  (state_q == S_HBLK),
    .in_vblk  (state_q == S_VBLK),
    .eor      (eor),
    .eof      (eof),
    .hblk_end (hblk_end),
    .vblk_end (vblk_end)
  );

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE:   if (accept) state_d = S_ACTIVE;
      S_ACTIVE: if (eof) state_d = S_VBLK;
                else if (eor) state_d = S_HBLK;
      S_HBLK:   if (hblk_end) state_d = S_ACTIVE;
      S_VBLK:   if (vblk_end) state_d = S_DRAIN;
      S_DRAIN:  if (frame_full || timeout_hit) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
                end
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= S_IDLE;
      done    <= 1'b0;
      rd_addr <= '0;
      hav_d1  <= 1'b0;
      o_hav   <= 1'b0;
      vav_d1  <= 1'b0;
      o_vav   <= 1'b0;
      o_data  <= '0;
    end else begin
      state_q <= state_d;
      done    <= done_d;
      if (state_q == S_IDLE) rd_addr <= '0;
      else if (rd_en)        rd_addr <= rd_addr + ADDR_WIDTH'(1);
      hav_d1  <= rd_en;
      o_hav   <= hav_d1;
      vav_d1  <= in_line;
      o_vav   <= vav_d1;
      o_data  <= rd_data;
    end
  end

  // cap_q counts accepted results one stage ahead of wr_en, so completion is known in the last write cycle.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      cap_q   <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en   <= f_wr_file && cap_room;
      wr_data <= f_data_out;
      if (accept)                     cap_q <= '0;
      else if (f_wr_file && cap_room) cap_q <= cap_q + (ADDR_WIDTH + 1)'(1);
      if (accept)     wr_addr <= '0;
      else if (wr_en) wr_addr <= wr_addr + ADDR_WIDTH'(1);
    end
  end

`ifdef SEQ_TIMEOUT_EN
  localparam int TW = cnt_w(TIMEOUT);
  logic [TW-1:0] to_q;

  assign timeout_hit = (state_q == S_DRAIN) && (to_q == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      to_q <= '0;
      err  <= 1'b0;
    end else begin
      if (state_q != S_DRAIN || f_wr_file) to_q <= '0;
      else                                 to_q <= to_q + TW'(1);
      if (accept)                                         err <= 1'b0;
      else if (timeout_hit || (f_wr_file && !cap_room))   err <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

endmodule

// File: tb/tb_filter_frame_sequencer.sv
// Directed bench for filter_frame_sequencer (8x4 frame, HBLANK 2, VBLANK 24) with a behavioural 3x3 mean filter.
module tb_filter_frame_sequencer;

  localparam int W = 8, H = 4, HB = 2, VB = 24, TO = 64, AW = 8, DW = 8;
  localparam int LAT = 40;
`ifdef SEQ_TIMEOUT_EN
  localparam int TO_DONE = 126;
`else
  localparam int TO_DONE = -1;
`endif

  logic clk = 1'b0;
  logic rstb = 1'b1;
  logic start = 1'b0;
  logic busy, done, rd_en, o_hav, o_vav, wr_en;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [DW-1:0] rd_data = '0;
  logic [DW-1:0] o_data, wr_data;
  logic f_wr_file = 1'b0;
  logic [DW-1:0] f_data_out = '0;
`ifdef SEQ_TIMEOUT_EN
  logic err;
`endif

  int n_chk = 0, n_pass = 0, n_fail = 0;
  logic filt_en = 1'b1;
  logic [7:0] ramp [32];
  logic [7:0] img [32];
  logic [LAT-1:0] fpipe = '0;
  int in_idx = 0, out_idx = 0;

  filter_frame_sequencer #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WIDTH_IMG(W), .HEIGHT_IMG(H),
    .HBLANK(HB), .VBLANK(VB), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rstb(rstb), .start(start), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .o_hav(o_hav), .o_vav(o_vav), .o_data(o_data),
    .f_wr_file(f_wr_file), .f_data_out(f_data_out),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
`ifdef SEQ_TIMEOUT_EN
    , .err(err)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mean3(input logic [7:0] a [32], input int k);
    int s, rr, cc;
    s = 0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        rr = k / W + dr;
        cc = k % W + dc;
        if (rr < 0) rr = 0;
        if (rr > H - 1) rr = H - 1;
        if (cc < 0) cc = 0;
        if (cc > W - 1) cc = W - 1;
        s += int'(a[rr * W + cc]);
      end
    end
    return 8'(s / 9);
  endfunction

  function automatic bit exp_rd(input int c);
    return (c >= 0) && (c < H * (W + HB) - HB) && ((c % (W + HB)) < W);
  endfunction

  // Synchronous frame memory holding the ramp image.
  always @(posedge clk) if (rd_en) rd_data <= ramp[rd_addr[4:0]];

  // Filter model: emits the clamped 3x3 mean of each pixel LAT cycles after it arrives.
  always @(negedge clk) begin
    if (!rstb) begin
      fpipe = '0;
      in_idx = 0;
      out_idx = 0;
      f_wr_file = 1'b0;
    end else begin
      f_wr_file = fpipe[LAT-1];
      if (f_wr_file) begin
        f_data_out = mean3(img, out_idx);
        out_idx = (out_idx + 1) % 32;
      end
      fpipe = {fpipe[LAT-2:0], o_hav & filt_en};
      if (o_hav) begin
        img[in_idx] = o_data;
        in_idx = (in_idx + 1) % 32;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Starts a frame and follows it cycle by cycle; returns at the negedge of the done cycle (or on budget expiry).
  task automatic do_frame(input int exp_done, input int exp_wr, input bit sb);
    int n_wr, hav_n, last_wr, done_c;
    n_wr = 0; hav_n = 0; last_wr = -10; done_c = -1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 300 && done_c < 0; c++) begin
      if (c < 45) begin
        chk("rd_en", rd_en, exp_rd(c));
        chk("o_hav", o_hav, exp_rd(c - 2));
        chk("o_vav", o_vav, (c >= 2 && c <= H * (W + HB) - HB + 1));
        if (exp_rd(c)) chk("rd_addr", rd_addr, (c / (W + HB)) * W + c % (W + HB));
      end
      if (o_hav) begin
        chk("o_data", o_data, hav_n);
        hav_n++;
      end
      if (c == 0) begin
        chk("busy_start", busy, 1);
        chk("wr_addr_clr", wr_addr, 0);
`ifdef SEQ_TIMEOUT_EN
        chk("err_clr", err, 0);
`endif
      end
      if (wr_en) begin
        chk("wr_addr", wr_addr, n_wr);
        chk("wr_data", wr_data, mean3(ramp, n_wr % 32));
        n_wr++;
        last_wr = c;
      end
      if (done) begin
        done_c = c;
        chk("busy_at_done", busy, 0);
        if (exp_wr > 0) chk("done_after_last_wr", c, last_wr + 1);
      end
      if (sb) start = (c == 12);
      if (done_c < 0) @(negedge clk);
    end
    chk("done_cycle", done_c, exp_done);
    chk("wr_count", n_wr, exp_wr);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) ramp[i] = 8'(i);
    #2 rstb = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_o_hav", o_hav, 0);
    chk("rst_o_vav", o_vav, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    rstb = 1'b1;
    repeat (2) @(negedge clk);

    // Read sequencing and full ramp frame.
    do_frame(81, 32, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("no_extra_done", done, 0);
      chk("idle_busy", busy, 0);
    end

    // Start at rd_addr 10 and again in the done cycle: both ignored.
    do_frame(81, 32, 1'b1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_at_done_busy", busy, 0);
    chk("start_at_done_rd_en", rd_en, 0);
    @(negedge clk);
    chk("start_at_done_done", done, 0);

    // Reset mid-row.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    chk("pre_rst_rd_addr", rd_addr, 13);
    rstb = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rd_en", rd_en, 0);
    chk("mid_rst_rd_addr", rd_addr, 0);
    chk("mid_rst_o_hav", o_hav, 0);
    chk("mid_rst_o_vav", o_vav, 0);
    chk("mid_rst_o_data", o_data, 0);
    chk("mid_rst_wr_en", wr_en, 0);
    chk("mid_rst_done", done, 0);
`ifdef SEQ_TIMEOUT_EN
    chk("mid_rst_err", err, 0);
`endif
    @(negedge clk);
    rstb = 1'b1;
    @(negedge clk);
    do_frame(81, 32, 1'b0);

    // Back-to-back: start in the cycle after done.
    @(negedge clk);
    do_frame(81, 32, 1'b0);

    // Drain with the filter silenced.
    filt_en = 1'b0;
    @(negedge clk);
    do_frame(TO_DONE, 0, 1'b0);
`ifdef SEQ_TIMEOUT_EN
    chk("timeout_err", err, 1);
    repeat (3) @(negedge clk);
    chk("err_sticky", err, 1);
    chk("timeout_idle", busy, 0);
`else
    chk("drain_busy_held", busy, 1);
    rstb = 1'b0;
    @(negedge clk);
    rstb = 1'b1;
`endif
    filt_en = 1'b1;
    repeat (2) @(negedge clk);
    do_frame(81, 32, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
